// File: rtl/vga_pkg.sv
// Shared XGA 1024x768 timing constants, counter types and the sync/blank decode
// used by vga_timing and the vga_if bundle.
package vga_pkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned RGB_W = 12;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int H_TOTAL_DEF = 1344;
  localparam int V_TOTAL_DEF = 806;

  localparam cnt_t HOR_PIXELS   = 11'd1024;
  localparam cnt_t VER_PIXELS   = 11'd768;
  localparam cnt_t H_SYNC_START = 11'd1048;
  localparam cnt_t H_SYNC_W     = 11'd136;
  localparam cnt_t V_SYNC_START = 11'd771;
  localparam cnt_t V_SYNC_W     = 11'd6;

  localparam cnt_t H_SYNC_END = H_SYNC_START + H_SYNC_W;
  localparam cnt_t V_SYNC_END = V_SYNC_START + V_SYNC_W;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
  } vga_flags_t;

  // Active-high sync/blank flags for a given raster position.
  function automatic vga_flags_t vga_decode(input cnt_t h, input cnt_t v);
    vga_flags_t f;
    f.hblnk = (h >= HOR_PIXELS);
    f.vblnk = (v >= VER_PIXELS);
    f.hsync = (h >= H_SYNC_START) && (h < H_SYNC_END);
    f.vsync = (v >= V_SYNC_START) && (v < V_SYNC_END);
    return f;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Raster bundle carried from the timing generator to the paint stages:
// counters, active-high sync/blank flags and a 12-bit colour field.
interface vga_if;
  import vga_pkg::*;

  cnt_t             hcount;
  cnt_t             vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
  logic [RGB_W-1:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_timing.sv
// Raster counter and sync/blank generator; steps one pixel per pix_en strobe.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  vga_if.out         vga_out,
  output logic       frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  if ((H_TOTAL < 1) || (H_TOTAL > 2047) || (V_TOTAL < 1) || (V_TOTAL > 2047)) begin : g_param_check
    $error("vga_timing: H_TOTAL/V_TOTAL must lie in 1..2047");
  end

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  cnt_t       r_hcount;
  cnt_t       r_vcount;
  vga_flags_t r_flags;
  logic       r_frame_start;

  cnt_t       w_hnext;
  cnt_t       w_vnext;
  logic       w_hwrap;
  logic       w_origin;
  vga_flags_t w_flags;

  // Flags are decoded from the next position so they register together with
  // the counters they describe.
  always_comb begin
    w_hwrap = (r_hcount == H_LAST);
    w_hnext = w_hwrap ? '0 : r_hcount + cnt_t'(1);
    w_vnext = r_vcount;
    if (w_hwrap) begin
      w_vnext = (r_vcount == V_LAST) ? '0 : r_vcount + cnt_t'(1);
    end
    w_origin = (w_hnext == '0) && (w_vnext == '0);
    w_flags  = vga_decode(w_hnext, w_vnext);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_flags       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (pix_en) begin
        r_hcount      <= w_hnext;
        r_vcount      <= w_vnext;
        r_flags       <= w_flags;
        r_frame_start <= w_origin;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
    end else if (pix_en && w_origin) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign vga_out.hcount = r_hcount;
  assign vga_out.vcount = r_vcount;
  assign vga_out.hsync  = r_flags.hsync;
  assign vga_out.vsync  = r_flags.vsync;
  assign vga_out.hblnk  = r_flags.hblnk;
  assign vga_out.vblnk  = r_flags.vblnk;
  assign vga_out.rgb    = '0;
  assign frame_start    = r_frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default-size raster for horizontal behaviour,
// a 2-clock-per-line instance for vertical behaviour and frame wrap.
module tb_vga_timing;
  import vga_pkg::*;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic pix_en = 1'b0;
  logic fs;
  logic fs_v;

  vga_if bus();
  vga_if bus_v();

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] fc;
  logic [7:0] fc_v;
  logic [7:0] fc_f;
  logic       fs_f;
  vga_if      bus_f();
`endif

  vga_timing dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .vga_out     (bus),
    .frame_start (fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt   (fc)
`endif
  );

  vga_timing #(.H_TOTAL(2), .V_TOTAL(806)) dut_v (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .vga_out     (bus_v),
    .frame_start (fs_v)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt   (fc_v)
`endif
  );

`ifdef VGA_TIMING_FRAME_CNT_EN
  vga_timing #(.H_TOTAL(4), .V_TOTAL(2)) dut_f (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .vga_out     (bus_f),
    .frame_start (fs_f),
    .frame_cnt   (fc_f)
  );
`endif

  // clock / reset
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // scoreboard comparison
  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks; all of them return on a falling edge
  task automatic do_reset();
    @(negedge clk);
    pix_en = 1'b0;
    rst    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic advance(input int n);
    if (n > 0) begin
      pix_en = 1'b1;
      repeat (n) @(negedge clk);
      pix_en = 1'b0;
    end
  endtask

  typedef struct {
    int   step;
    int   h;
    int   v;
    logic hs;
    logic hb;
    logic fs;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int   cur;
    int   pat[4];
    int   exp_h[4];
    int   exp_hb[4];
    int   hm;
    int   errs;
    int   hs_cnt;
    int   hs_first;
    int   vs_cnt;
    int   vs_first;
    int   vb_cnt;
    int   fs_cnt;
    int   mh;
    int   mv;

    vecs[0]  = '{0,    0,    0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1,    1,    0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1023, 1023, 0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1024, 1024, 0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1047, 1047, 0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1048, 1048, 0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1183, 1183, 0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1184, 1184, 0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1343, 1343, 0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1344, 0,    1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1345, 1,    1, 1'b0, 1'b0, 1'b0};

    // table: continuous pix_en from reset across the first line wrap
    do_reset();
    cur = 0;
    for (int i = 0; i < 11; i++) begin
      advance(vecs[i].step - cur);
      cur = vecs[i].step;
      check($sformatf("vec%0d.hcount", i), bus.hcount, vecs[i].h);
      check($sformatf("vec%0d.vcount", i), bus.vcount, vecs[i].v);
      check($sformatf("vec%0d.hsync", i), bus.hsync, vecs[i].hs);
      check($sformatf("vec%0d.hblnk", i), bus.hblnk, vecs[i].hb);
      check($sformatf("vec%0d.vsync", i), bus.vsync, 0);
      check($sformatf("vec%0d.vblnk", i), bus.vblnk, 0);
      check($sformatf("vec%0d.frame_start", i), fs, vecs[i].fs);
      check($sformatf("vec%0d.rgb", i), bus.rgb, 0);
    end

    // rest of line 1: hsync width and position against an independent model
    hm = 1; errs = 0; hs_cnt = 0; hs_first = -1;
    pix_en = 1'b1;
    for (int k = 0; k < 1343; k++) begin
      @(negedge clk);
      hm = (hm + 1) % 1344;
      if (bus.hcount !== hm) errs++;
      if (bus.hsync !== ((hm >= 1048) && (hm < 1184))) errs++;
      if (bus.hblnk !== (hm >= 1024)) errs++;
      if (bus.hsync === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(bus.hcount);
      end
    end
    pix_en = 1'b0;
    check("line_sweep_errors", errs, 0);
    check("hsync_width", hs_cnt, 136);
    check("hsync_first_hcount", hs_first, 1048);
    check("line2_hcount", bus.hcount, 0);
    check("line2_vcount", bus.vcount, 2);

    // pix_en 1,0,0,1 across the hblnk edge: outputs frozen between strobes
    do_reset();
    advance(1022);
    pat    = '{1, 0, 0, 1};
    exp_h  = '{1023, 1023, 1023, 1024};
    exp_hb = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      pix_en = pat[i][0];
      @(negedge clk);
      pix_en = 1'b0;
      check($sformatf("toggle%0d.hcount", i), bus.hcount, exp_h[i]);
      check($sformatf("toggle%0d.hblnk", i), bus.hblnk, exp_hb[i]);
      check($sformatf("toggle%0d.vcount", i), bus.vcount, 0);
    end

    // asynchronous reset between edges in the middle of line 1
    do_reset();
    advance(1344 + 1100);
    check("pre_rst.hcount", bus.hcount, 1100);
    check("pre_rst.vcount", bus.vcount, 1);
    check("pre_rst.hsync", bus.hsync, 1);
    check("pre_rst.hblnk", bus.hblnk, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst.hcount", bus.hcount, 0);
    check("async_rst.vcount", bus.vcount, 0);
    check("async_rst.hsync", bus.hsync, 0);
    check("async_rst.hblnk", bus.hblnk, 0);
    check("async_rst.vsync", bus.vsync, 0);
    check("async_rst.vblnk", bus.vblnk, 0);
    check("async_rst.frame_start", fs, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle.frame_start", fs, 0);
    advance(1);
    check("resume.hcount", bus.hcount, 1);
    check("resume.vcount", bus.vcount, 0);
    check("resume.frame_start", fs, 0);

    // full frame on the 2-clock-per-line instance, ending at (1,805)->(0,0)
    do_reset();
    errs = 0; vs_cnt = 0; vs_first = -1; vb_cnt = 0; fs_cnt = 0;
    pix_en = 1'b1;
    for (int k = 1; k <= 1612; k++) begin
      @(negedge clk);
      mh = k % 2;
      mv = (k / 2) % 806;
      if (bus_v.hcount !== mh) errs++;
      if (bus_v.vcount !== mv) errs++;
      if (bus_v.vsync !== ((mv >= 771) && (mv < 777))) errs++;
      if (bus_v.vblnk !== (mv >= 768)) errs++;
      if (fs_v !== (k == 1612)) errs++;
      if (bus_v.vsync === 1'b1) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = int'(bus_v.vcount);
      end
      if (bus_v.vblnk === 1'b1) vb_cnt++;
      if (fs_v === 1'b1) fs_cnt++;
    end
    pix_en = 1'b0;
    check("frame_sweep_errors", errs, 0);
    check("vsync_cycles", vs_cnt, 12);
    check("vsync_first_vcount", vs_first, 771);
    check("vblnk_cycles", vb_cnt, 76);
    check("frame_start_count", fs_cnt, 1);
    check("wrap.hcount", bus_v.hcount, 0);
    check("wrap.vcount", bus_v.vcount, 0);
    check("wrap.frame_start", fs_v, 1);
    @(negedge clk);
    check("wrap_idle.frame_start", fs_v, 0);
    check("wrap_idle.hcount", bus_v.hcount, 0);
    check("wrap_idle.vcount", bus_v.vcount, 0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // 8 steps per frame on the small instance; 257 frames wraps to 1
    do_reset();
    check("frame_cnt.reset", fc_f, 0);
    advance(8);
    check("frame_cnt.one_frame", fc_f, 1);
    check("frame_cnt.with_start", fs_f, 1);
    advance(256 * 8);
    check("frame_cnt.257_frames", fc_f, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL take parameter H_TOTAL, default 1344, meaning total clocks per line.
REQ-002 SHALL take parameter V_TOTAL, default 806, meaning total lines per frame.
REQ-003 SHALL have port clk  input  1  pixel-domain clock, all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low; this polarity and synchronicity are fixed.
REQ-005 SHALL have port pix_en  input  1  pixel advance strobe; counters step only when high.
REQ-006 SHALL have port vga_out  vga_if.out  38  hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0].
REQ-007 SHALL have port frame_start  output  1  one-strobe pulse at frame origin.

Function
REQ-008 SHALL drive every output from a register; no combinational input-to-output path.
REQ-009 SHALL increment hcount on each clk edge with pix_en=1; hold all outputs when pix_en=0.
REQ-010 SHALL wrap hcount from H_TOTAL-1 to 0 and, in that same step, increment vcount.
REQ-011 SHALL wrap vcount from V_TOTAL-1 to 0 when hcount also wraps; both reach 0 in one step.
REQ-012 SHALL assert hblnk iff hcount >= HOR_PIXELS (1024), i.e. 1024..H_TOTAL-1.
REQ-013 SHALL assert hsync iff H_SYNC_START (1048) <= hcount < H_SYNC_START+H_SYNC_W (1048+136).
REQ-014 SHALL assert vblnk iff vcount >= VER_PIXELS (768).
REQ-015 SHALL assert vsync iff V_SYNC_START (771) <= vcount < V_SYNC_START+V_SYNC_W (771+6).
REQ-016 SHALL keep hsync, vsync, hblnk and vblnk cycle-aligned with the hcount/vcount values they describe, with zero relative latency.
REQ-017 SHALL implement sync as active-high; pin polarity is applied at top level.
REQ-018 SHALL drive vga_out.rgb constant 12'h0_0_0; downstream stages paint.
REQ-019 SHALL pulse frame_start high for exactly one clk cycle when a pix_en step lands on (0,0); low otherwise.
REQ-020 SHALL size counters at 11 bits; parameters > 2047 are illegal and are checked by an elaboration assertion.

Reset
REQ-021 SHALL on rst=0 immediately force hcount=0, vcount=0, all sync/blank flags 0, rgb=0, frame_start=0.
REQ-022 SHALL resume from (0,0) on the first pix_en step after rst release, producing hcount=1; the reset state itself does not raise frame_start.
REQ-023 SHALL abandon the current frame on mid-frame reset; no partial-line completion.

Configuration
REQ-024 SHALL, with macro VGA_TIMING_FRAME_CNT_EN defined, add output frame_cnt [7:0], reset 0, incremented in the cycle frame_start asserts, wrapping 255->0.
REQ-025 SHALL, without VGA_TIMING_FRAME_CNT_EN, omit the frame_cnt port and logic entirely; all other behaviour is identical.

Structure
REQ-026 SHALL take HOR_PIXELS, VER_PIXELS, H_SYNC_START, H_SYNC_W, V_SYNC_START, V_SYNC_W and default totals from vga_pkg.
REQ-027 SHALL be a single module with no sub-module; the vga_if definition is shared, unmodified.

Verification
REQ-028 SHALL cover: pix_en=1 continuous from reset -> hcount 0..1343 then 0 with vcount 0->1; hblnk first high at hcount=1024.
REQ-029 SHALL cover: full frame -> hsync high exactly 136 clocks per line starting hcount=1048; vsync high lines 771..776 only.
REQ-030 SHALL cover: pix_en toggling 1,0,0,1 -> hcount steps only on strobe cycles; all outputs frozen in between.
REQ-031 SHALL cover: (hcount,vcount)=(1343,805) plus a pix_en step -> (0,0), frame_start=1 for one cycle.
REQ-032 SHALL cover: rst=0 asserted at (500,300) between clock edges -> all outputs 0 before the next edge.
REQ-033 SHALL cover: with VGA_TIMING_FRAME_CNT_EN, 257 frames -> frame_cnt=1; without it, the frame_cnt port is absent and compile is clean.
